// File: rtl/time_edit_cu.sv
`default_nettype none
// ============================================================================
//  Module      : time_edit_cu
//  Description : Cursor/step controller for editing an N-field clock value.
//                Moves a field cursor, emits field-indexed inc/dec strobes,
//                auto-repeats a held step key, abandons edit mode after a
//                period of inactivity, and produces a cursor blink flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_edit_cu #(
    parameter int NUM_FIELDS    = 3,
    parameter int FIELD_W       = 2,
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 10,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int BLINK_TICKS   = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               sw_setting,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    input  logic               up_level,
    input  logic               down_level,
    input  logic               i_uart_left,
    input  logic               i_uart_right,
    input  logic               i_uart_up,
    input  logic               i_uart_down,
    output logic [FIELD_W-1:0] o_field,
    output logic               o_inc,
    output logic               o_dec,
    output logic               o_editing,
    output logic               o_blink,
    output logic               o_timeout
);

    // One counter width shared by all tick counters, sized for the largest limit
    localparam int c_MAX_HR    = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int c_MAX_TB    = (TIMEOUT_TICKS > BLINK_TICKS) ? TIMEOUT_TICKS : BLINK_TICKS;
    localparam int c_MAX_TICKS = (c_MAX_HR > c_MAX_TB) ? c_MAX_HR : c_MAX_TB;
    localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD    = c_CNT_W'(HOLD_TICKS);
    localparam logic [c_CNT_W-1:0] c_REPEAT  = c_CNT_W'(REPEAT_TICKS);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_TICKS);
    localparam logic [c_CNT_W-1:0] c_BLINK   = c_CNT_W'(BLINK_TICKS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [FIELD_W-1:0] c_LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [FIELD_W-1:0] c_FIELD_ONE  = FIELD_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EDIT   = 2'd1;
    localparam logic [1:0] c_ST_REP_UP = 2'd2;
    localparam logic [1:0] c_ST_REP_DN = 2'd3;

    logic [1:0]         r_state, w_state_nx;
    logic               r_armed, w_armed_nx;
    logic [FIELD_W-1:0] r_field, w_field_nx;
    logic               r_inc, w_inc_nx;
    logic               r_dec, w_dec_nx;
    logic               r_editing;
    logic               r_blink, w_blink_nx;
    logic               r_timeout, w_timeout_nx;
    logic [c_CNT_W-1:0] r_step_cnt, w_step_nx;   // hold count in EDIT, repeat interval in REPEAT
    logic [c_CNT_W-1:0] r_idle_cnt, w_idle_nx;
    logic [c_CNT_W-1:0] r_blink_cnt, w_bcnt_nx;
    logic               r_hold_dn, w_hold_dn_nx; // direction the hold count belongs to

    logic w_l, w_r, w_u, w_d;
    logic w_mv_l, w_mv_r, w_move, w_step_u, w_step_d;
    logic w_hold_up, w_hold_dn;
    logic w_rep_up, w_rep_dn, w_event, w_rep_level;
    logic [c_CNT_W-1:0] w_step_inc, w_idle_inc, w_bcnt_inc, w_hold_base, w_hold_inc;

    // Merge button and UART sources; conflicting pairs cancel, a cursor move beats a step
    assign w_l      = left  | i_uart_left;
    assign w_r      = right | i_uart_right;
    assign w_u      = up    | i_uart_up;
    assign w_d      = down  | i_uart_down;
    assign w_mv_l   = w_l & ~w_r;
    assign w_mv_r   = w_r & ~w_l;
    assign w_move   = w_mv_l | w_mv_r;
    assign w_step_u = w_u & ~w_d & ~w_move;
    assign w_step_d = w_d & ~w_u & ~w_move;

    assign w_hold_up = up_level & ~down_level;
    assign w_hold_dn = down_level & ~up_level;

    // Saturating increments; the hold count restarts when the held direction flips
    assign w_step_inc  = (r_step_cnt == c_CNT_MAX) ? r_step_cnt : r_step_cnt + c_CNT_ONE;
    assign w_idle_inc  = (r_idle_cnt == c_CNT_MAX) ? r_idle_cnt : r_idle_cnt + c_CNT_ONE;
    assign w_bcnt_inc  = (r_blink_cnt == c_CNT_MAX) ? r_blink_cnt : r_blink_cnt + c_CNT_ONE;
    assign w_hold_base = (w_hold_dn != r_hold_dn) ? '0 : r_step_cnt;
    assign w_hold_inc  = (w_hold_base == c_CNT_MAX) ? w_hold_base : w_hold_base + c_CNT_ONE;

    // Next-state, counter and output decode
    always_comb begin
        w_state_nx   = r_state;
        w_armed_nx   = r_armed;
        w_field_nx   = r_field;
        w_inc_nx     = 1'b0;
        w_dec_nx     = 1'b0;
        w_timeout_nx = 1'b0;
        w_blink_nx   = r_blink;
        w_step_nx    = r_step_cnt;
        w_idle_nx    = r_idle_cnt;
        w_bcnt_nx    = r_blink_cnt;
        w_hold_dn_nx = r_hold_dn;
        w_rep_up     = 1'b0;
        w_rep_dn     = 1'b0;
        w_event      = 1'b0;
        w_rep_level  = (r_state == c_ST_REP_UP) ? up_level : down_level;

        if (!sw_setting) begin
            w_state_nx = c_ST_IDLE;
            w_armed_nx = 1'b1;
            w_field_nx = '0;
            w_blink_nx = 1'b0;
            w_step_nx  = '0;
            w_idle_nx  = '0;
            w_bcnt_nx  = '0;
        end else if (r_state == c_ST_IDLE) begin
            if (r_armed) begin
                w_state_nx = c_ST_EDIT;
                w_field_nx = '0;
                w_blink_nx = 1'b1;
                w_step_nx  = '0;
                w_idle_nx  = '0;
                w_bcnt_nx  = '0;
            end
        end else begin
            // Hold detection in EDIT, periodic repeat in REPEAT_UP/REPEAT_DN
            if (r_state == c_ST_EDIT) begin
                if (w_hold_up || w_hold_dn) begin
                    w_hold_dn_nx = w_hold_dn;
                    if (i_tick) begin
                        if (w_hold_inc == c_HOLD) begin
                            w_step_nx  = '0;
                            w_rep_up   = w_hold_up;
                            w_rep_dn   = w_hold_dn;
                            w_state_nx = w_hold_up ? c_ST_REP_UP : c_ST_REP_DN;
                        end else begin
                            w_step_nx = w_hold_inc;
                        end
                    end else begin
                        w_step_nx = w_hold_base;
                    end
                end else begin
                    w_step_nx = '0;
                end
            end else if (!w_rep_level) begin
                w_state_nx = c_ST_EDIT;
                w_step_nx  = '0;
            end else if (i_tick) begin
                if (w_step_inc == c_REPEAT) begin
                    w_step_nx = '0;
                    w_rep_up  = (r_state == c_ST_REP_UP);
                    w_rep_dn  = (r_state == c_ST_REP_DN);
                end else begin
                    w_step_nx = w_step_inc;
                end
            end

            // Cursor movement with wrap in both directions
            if (w_mv_l) begin
                w_field_nx = (r_field == c_LAST_FIELD) ? '0 : r_field + c_FIELD_ONE;
            end else if (w_mv_r) begin
                w_field_nx = (r_field == '0) ? c_LAST_FIELD : r_field - c_FIELD_ONE;
            end

            // A repeat strobe takes the slot over a step pulse; step pulses are ignored while repeating
            if (!w_move) begin
                if (w_rep_up || w_rep_dn) begin
                    w_inc_nx = w_rep_up;
                    w_dec_nx = w_rep_dn;
                end else if (r_state == c_ST_EDIT) begin
                    w_inc_nx = w_step_u;
                    w_dec_nx = w_step_d;
                end
            end

            w_event = w_move | w_rep_up | w_rep_dn |
                      ((r_state == c_ST_EDIT) & (w_step_u | w_step_d));

            if (w_event) begin
                w_blink_nx = 1'b1;
                w_bcnt_nx  = '0;
            end else if (i_tick) begin
                if (w_bcnt_inc == c_BLINK) begin
                    w_blink_nx = ~r_blink;
                    w_bcnt_nx  = '0;
                end else begin
                    w_bcnt_nx = w_bcnt_inc;
                end
            end

            // Inactivity only accumulates in EDIT; expiry disarms until the switch is cycled
            if (w_event) begin
                w_idle_nx = '0;
            end else if (i_tick && (r_state == c_ST_EDIT)) begin
                if (w_idle_inc == c_TIMEOUT) begin
                    w_state_nx   = c_ST_IDLE;
                    w_armed_nx   = 1'b0;
                    w_field_nx   = '0;
                    w_blink_nx   = 1'b0;
                    w_timeout_nx = 1'b1;
                    w_step_nx    = '0;
                    w_idle_nx    = '0;
                    w_bcnt_nx    = '0;
                end else begin
                    w_idle_nx = w_idle_inc;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_armed     <= 1'b1;
            r_field     <= '0;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_editing   <= 1'b0;
            r_blink     <= 1'b0;
            r_timeout   <= 1'b0;
            r_step_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_blink_cnt <= '0;
            r_hold_dn   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_armed     <= w_armed_nx;
            r_field     <= w_field_nx;
            r_inc       <= w_inc_nx;
            r_dec       <= w_dec_nx;
            r_editing   <= (w_state_nx != c_ST_IDLE);
            r_blink     <= w_blink_nx;
            r_timeout   <= w_timeout_nx;
            r_step_cnt  <= w_step_nx;
            r_idle_cnt  <= w_idle_nx;
            r_blink_cnt <= w_bcnt_nx;
            r_hold_dn   <= w_hold_dn_nx;
        end
    end

    assign o_field   = r_field;
    assign o_inc     = r_inc;
    assign o_dec     = r_dec;
    assign o_editing = r_editing;
    assign o_blink   = r_blink;
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_time_edit_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_edit_cu
//  Description : Self-checking bench for time_edit_cu: directed scenarios plus
//                randomized traffic compared against a tick-age reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_edit_cu;

    localparam int NUM_FIELDS = 3;
    localparam int FIELD_W    = 2;
    localparam int HOLD       = 50;
    localparam int REPEAT     = 10;
    localparam int TIMEOUT    = 1000;
    localparam int BLINK      = 50;

    logic clk = 1'b0, reset = 1'b1, i_tick = 1'b0, sw_setting = 1'b0;
    logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic up_level = 1'b0, down_level = 1'b0;
    logic i_uart_left = 1'b0, i_uart_right = 1'b0, i_uart_up = 1'b0, i_uart_down = 1'b0;
    logic [FIELD_W-1:0] o_field;
    logic o_inc, o_dec, o_editing, o_blink, o_timeout;

    time_edit_cu #(
        .NUM_FIELDS(NUM_FIELDS), .FIELD_W(FIELD_W), .HOLD_TICKS(HOLD),
        .REPEAT_TICKS(REPEAT), .TIMEOUT_TICKS(TIMEOUT), .BLINK_TICKS(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .i_tick(i_tick), .sw_setting(sw_setting),
        .left(left), .right(right), .up(up), .down(down),
        .up_level(up_level), .down_level(down_level),
        .i_uart_left(i_uart_left), .i_uart_right(i_uart_right),
        .i_uart_up(i_uart_up), .i_uart_down(i_uart_down),
        .o_field(o_field), .o_inc(o_inc), .o_dec(o_dec),
        .o_editing(o_editing), .o_blink(o_blink), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, inc_seen = 0, timeout_seen = 0;

    // Reference model: mode 0 idle, 1 edit, 2 repeat-up, 3 repeat-down.
    // Hold/repeat is tracked as "consecutive ticks held", blink and timeout as tick ages.
    int m_mode, m_field, m_hold_up, m_hold_dn, m_idle_age, m_blink_age;
    bit m_armed, m_inc, m_dec, m_timeout;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_hold_up = 0; m_hold_dn = 0;
        m_idle_age = 0; m_blink_age = 0; m_armed = 1;
        m_inc = 0; m_dec = 0; m_timeout = 0;
    endtask

    task automatic model_clear_ages();
        m_hold_up = 0; m_hold_dn = 0; m_idle_age = 0; m_blink_age = 0;
    endtask

    task automatic model_step();
        bit bl, br, bu, bd, mvl, mvr, mv, su, sd, rep_up, rep_dn, ev, to, lvl;
        int nmode, t;
        bl = left | i_uart_left;  br = right | i_uart_right;
        bu = up | i_uart_up;      bd = down | i_uart_down;
        mvl = bl && !br;  mvr = br && !bl;  mv = mvl || mvr;
        su = bu && !bd && !mv;  sd = bd && !bu && !mv;
        t = i_tick ? 1 : 0;
        m_inc = 0; m_dec = 0; m_timeout = 0;
        rep_up = 0; rep_dn = 0; to = 0;
        nmode = m_mode;
        if (!sw_setting) begin
            m_mode = 0; m_armed = 1; m_field = 0; model_clear_ages();
        end else if (m_mode == 0) begin
            if (m_armed) begin m_mode = 1; m_field = 0; model_clear_ages(); end
        end else begin
            if (m_mode == 1) begin
                m_hold_up = (up_level && !down_level) ? m_hold_up + t : 0;
                m_hold_dn = (down_level && !up_level) ? m_hold_dn + t : 0;
                if (t == 1 && m_hold_up == HOLD) begin rep_up = 1; nmode = 2; end
                if (t == 1 && m_hold_dn == HOLD) begin rep_dn = 1; nmode = 3; end
            end else begin
                lvl = (m_mode == 2) ? up_level : down_level;
                if (!lvl) begin
                    nmode = 1; m_hold_up = 0; m_hold_dn = 0;
                end else if (t == 1) begin
                    if (m_mode == 2) begin
                        m_hold_up++;
                        rep_up = ((m_hold_up - HOLD) % REPEAT == 0);
                    end else begin
                        m_hold_dn++;
                        rep_dn = ((m_hold_dn - HOLD) % REPEAT == 0);
                    end
                end
            end
            ev = mv || rep_up || rep_dn || (m_mode == 1 && (su || sd));
            if (!mv) begin
                if (rep_up || rep_dn) begin m_inc = rep_up; m_dec = rep_dn; end
                else if (m_mode == 1) begin m_inc = su; m_dec = sd; end
            end
            if (mvl) m_field = (m_field + 1) % NUM_FIELDS;
            if (mvr) m_field = (m_field + NUM_FIELDS - 1) % NUM_FIELDS;
            if (ev) m_blink_age = 0; else m_blink_age += t;
            if (ev) m_idle_age = 0;
            else if (t == 1 && m_mode == 1) begin
                m_idle_age++;
                if (m_idle_age == TIMEOUT) to = 1;
            end
            m_mode = nmode;
            if (to) begin
                m_mode = 0; m_armed = 0; m_field = 0; m_timeout = 1; model_clear_ages();
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_blink;
        exp_blink = (m_mode != 0) && ((m_blink_age / BLINK) % 2 == 0);
        check_val("o_field",   32'(o_field),   32'(m_field));
        check_val("o_inc",     32'(o_inc),     32'(m_inc));
        check_val("o_dec",     32'(o_dec),     32'(m_dec));
        check_val("o_editing", 32'(o_editing), 32'(m_mode != 0));
        check_val("o_blink",   32'(o_blink),   32'(exp_blink));
        check_val("o_timeout", 32'(o_timeout), 32'(m_timeout));
    endtask

    // One clock: model consumes the current inputs, DUT is sampled 1 unit after the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (o_inc) inc_seen++;
        if (o_timeout) timeout_seen++;
        check_outputs();
        left = 0; right = 0; up = 0; down = 0;
        i_uart_left = 0; i_uart_right = 0; i_uart_up = 0; i_uart_down = 0;
    endtask

    initial begin
        int exp_l[4] = '{1, 2, 0, 1};
        int exp_r[2] = '{0, 2};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 0;

        // Enter edit mode
        sw_setting = 1;
        cyc();
        check_val("enter_edit", 32'(o_editing), 1);

        // Cursor moves: L x4, R x2, then L&R cancel
        for (int i = 0; i < 4; i++) begin left = 1; cyc(); check_val("cursor_l", 32'(o_field), 32'(exp_l[i])); end
        for (int i = 0; i < 2; i++) begin i_uart_right = 1; cyc(); check_val("cursor_r", 32'(o_field), 32'(exp_r[i])); end
        left = 1; right = 1; cyc();
        check_val("cursor_lr", 32'(o_field), 2);

        // Step pulses
        up = 1; cyc(); check_val("u_inc", 32'(o_inc), 1);
        cyc();         check_val("u_inc_1cyc", 32'(o_inc), 0);
        up = 1; down = 1; cyc();
        check_val("ud_inc", 32'(o_inc), 0);
        check_val("ud_dec", 32'(o_dec), 0);
        left = 1; up = 1; cyc();
        check_val("lu_field", 32'(o_field), 0);
        check_val("lu_inc", 32'(o_inc), 0);

        // Hold-to-repeat: 80 ticks held -> strobes at 50,60,70,80
        inc_seen = 0; up_level = 1; i_tick = 1;
        repeat (80) cyc();
        check_val("hold_strobes", 32'(inc_seen), 4);
        up_level = 0;
        repeat (20) cyc();
        check_val("release_strobes", 32'(inc_seen), 4);
        check_val("release_edit", 32'(o_editing), 1);

        // Inactivity timeout, then disarmed until the switch is cycled
        timeout_seen = 0;
        repeat (1100) cyc();
        check_val("timeout_pulses", 32'(timeout_seen), 1);
        check_val("timeout_idle", 32'(o_editing), 0);
        repeat (5) cyc();
        check_val("stay_idle", 32'(o_editing), 0);
        i_tick = 0; sw_setting = 0; cyc();
        sw_setting = 1; cyc();
        check_val("reenter_edit", 32'(o_editing), 1);
        check_val("reenter_field", 32'(o_field), 0);

        // Blink: toggles at 50 and 100, U at 120 restarts the half-period
        for (int k = 1; k <= 170; k++) begin
            i_tick = 1;
            if (k == 120) up = 1;
            cyc();
            if (k inside {49, 50, 100, 120, 150, 169, 170})
                check_val("blink", 32'(o_blink), (k == 50 || k == 170) ? 32'd0 : 32'd1);
        end

        // Async reset in the middle of REPEAT_UP at field 2
        i_tick = 0; left = 1; cyc(); left = 1; cyc();
        up_level = 1; i_tick = 1;
        repeat (55) cyc();
        check_val("rep_field", 32'(o_field), 2);
        #2 reset = 1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0; up_level = 0; i_tick = 0;
        cyc();
        check_val("post_rst_edit", 32'(o_editing), 1);
        check_val("post_rst_field", 32'(o_field), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 8000; n++) begin
            i_tick = ($urandom_range(0, 1) == 1);
            if (sw_setting && $urandom_range(0, 399) == 0) sw_setting = 0;
            else if (!sw_setting && $urandom_range(0, 3) == 0) sw_setting = 1;
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin up_level = 0; down_level = 0; end
                    1: begin up_level = 1; down_level = 0; end
                    2: begin up_level = 0; down_level = 1; end
                    default: begin up_level = 1; down_level = 1; end
                endcase
            end
            left         = ($urandom_range(0, 31) == 0);
            right        = ($urandom_range(0, 31) == 0);
            up           = ($urandom_range(0, 31) == 0);
            down         = ($urandom_range(0, 31) == 0);
            i_uart_left  = ($urandom_range(0, 63) == 0);
            i_uart_right = ($urandom_range(0, 63) == 0);
            i_uart_up    = ($urandom_range(0, 63) == 0);
            i_uart_down  = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_edit_cu.md
Name: time_edit_cu

Overview:
- Parametrised cursor and step controller for editing an N-field clock value (e.g. sec/min/hour, or hh/mm/ss/centi).
- Sits between the button debouncers / UART command decoder and the watch datapath. Emits field-indexed increment/decrement strobes.
- Adds three behaviours: hold-to-auto-repeat, inactivity timeout back to run mode, and a cursor blink flag for the FND driver.

Parameters:
- NUM_FIELDS, 3, number of editable fields (2..8).
- FIELD_W, 2, cursor width; must satisfy 2^FIELD_W >= NUM_FIELDS.
- HOLD_TICKS, 50, i_tick count a step key must be held before auto-repeat starts.
- REPEAT_TICKS, 10, i_tick period between auto-repeat strobes.
- TIMEOUT_TICKS, 1000, i_tick count with no user event before edit mode is abandoned.
- BLINK_TICKS, 50, i_tick count per blink half-period.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_tick  in  1  one-cycle timebase strobe (10 ms)
- sw_setting  in  1  edit-enable level switch
- left, right, up, down  in  1 each  one-cycle debounced button pulses
- up_level, down_level  in  1 each  debounced held levels of the up/down buttons
- i_uart_left, i_uart_right, i_uart_up, i_uart_down  in  1 each  one-cycle UART command pulses
- o_field  out  FIELD_W  current cursor field index
- o_inc  out  1  one-cycle increment strobe for o_field
- o_dec  out  1  one-cycle decrement strobe for o_field
- o_editing  out  1  high while in EDIT or REPEAT
- o_blink  out  1  cursor-visible flag
- o_timeout  out  1  one-cycle pulse when edit mode exits on inactivity

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; all counters 0; armed=1.
- Event definitions:
  - L = left|i_uart_left; R = right|i_uart_right; U = up|i_uart_up; D = down|i_uart_down.
  - L&R in the same cycle: both ignored. U&D in the same cycle: both ignored.
  - L or R valid in the same cycle as U or D: the cursor move wins and the step is dropped.
- All outputs are registered; o_inc/o_dec assert exactly one cycle after the qualifying input cycle.
- IDLE:
  - Entry condition: sw_setting=1 and armed=1 -> EDIT; o_field=0; timeout counter cleared; o_blink=1.
  - sw_setting=0 sets armed=1.
- EDIT:
  - L: o_field+1, wrapping NUM_FIELDS-1 -> 0.
  - R: o_field-1, wrapping 0 -> NUM_FIELDS-1.
  - U: o_inc pulse. D: o_dec pulse.
  - up_level held (down_level low) for HOLD_TICKS consecutive i_tick -> REPEAT_UP. Symmetric for down_level -> REPEAT_DN.
  - Hold counter clears whenever the held level drops or both levels are high.
- REPEAT_UP / REPEAT_DN:
  - First repeat strobe fires on the tick that completes the hold count.
  - Subsequent strobes every REPEAT_TICKS ticks.
  - Held level falls -> EDIT, with no extra strobe.
  - L/R is still honoured (cursor moves, repeat continues on the new field).
- Timeout:
  - In EDIT/REPEAT, any L/R/U/D event or repeat strobe clears the counter.
  - Reaching TIMEOUT_TICKS ticks -> IDLE; o_timeout pulses 1 cycle; armed=0, so sw_setting must go low then high to re-enter.
  - The counter is frozen in REPEAT states.
- sw_setting=0 in any state -> IDLE next cycle. No o_timeout pulse; no strobe is emitted that cycle.
- o_blink:
  - Toggles every BLINK_TICKS ticks in EDIT/REPEAT.
  - Forced to 1 on any event (counter cleared).
  - 0 in IDLE.
- o_editing=1 exactly in EDIT/REPEAT_UP/REPEAT_DN.
- Counter widths: ceil(log2(max tick parameter + 1)). All counters saturate rather than wrap.

Test Plan:
- Reset mid-REPEAT_UP with o_field=2 -> all outputs 0 immediately (async), state IDLE; with sw_setting still 1 -> EDIT on the next clock with o_field=0.
- NUM_FIELDS=3, sw_setting=1, L pulses x4 -> o_field 1,2,0,1; then R x2 -> 0,2; L&R in the same cycle -> o_field unchanged.
- In EDIT, U pulse -> o_inc high exactly 1 cycle, one clock later; U and D in the same cycle -> no strobe; L with U in the same cycle -> cursor moves, no o_inc.
- up_level held for 50+30 ticks (HOLD=50, REPEAT=10) -> o_inc strobes at tick 50, 60, 70, 80 (4 total); release -> EDIT, no further strobes.
- No input for 1000 ticks in EDIT -> o_timeout 1-cycle pulse, o_editing=0; sw_setting held 1 stays IDLE; toggle 0 -> 1 -> EDIT re-entered, o_field=0.
- BLINK_TICKS=50 in EDIT: o_blink toggles at ticks 50, 100; U pulse at tick 120 -> o_blink=1 and the next toggle occurs 50 ticks later.
